// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control unit: opcodes, IR field positions, sequencer states.
// No logic and no latency; flow control is handled by the modules that import it.
package cpu_ctrl_pkg;

  localparam int OPW = 5;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [2:0] {
    S_HALT = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6
  } state_t;

endpackage

// File: rtl/control_unit_ir_decode.sv
// Opcode classifier: exactly one of rtype/nop/halt/illegal is high for any opcode.
// Purely combinational, zero latency, no flow control.
module ir_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output logic           is_rtype,
  output logic           is_nop,
  output logic           is_halt,
  output logic           is_illegal
);

  always_comb begin
    is_rtype   = 1'b0;
    is_nop     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: is_rtype = 1'b1;
      OP_NOP:                        is_nop   = 1'b1;
      OP_HALT:                       is_halt  = 1'b1;
      default:                       is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer for the single-bus datapath; strobes decode from state (and IR in T3/T4).
// Fetch stalls in T1 until mem_ready; R-type takes 6 cycles, NOP/HALT/illegal 4; stop halts at the next boundary.
module control_unit #(
  parameter int OPW = 5
) (
  input  logic           clock,
  input  logic           clear,
  input  logic [31:0]    IR,
  input  logic           mem_ready,
  input  logic           start,
  input  logic           stop,
  output logic           PCout,
  output logic           Zlowout,
  output logic           MDRout,
  output logic           MARin,
  output logic           MDRin,
  output logic           PCin,
  output logic           IRin,
  output logic           Yin,
  output logic           Zin,
  output logic           IncPC,
  output logic           Read,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic [OPW-1:0] alu_op,
  output logic           run,
  output logic           illegal
);

  cpu_ctrl_pkg::state_t state_q, state_d;
  logic stop_pend, stop_pend_d, stop_any;
  logic [cpu_ctrl_pkg::OPW-1:0] opcode;
  logic is_rtype, is_nop, is_halt, is_illegal;
  // Register fields are consumed by the select-and-encode logic, not here.
  logic unused_ir;

  assign opcode    = IR[cpu_ctrl_pkg::OP_HI:cpu_ctrl_pkg::OP_LO];
  assign unused_ir = ^IR[cpu_ctrl_pkg::OP_LO-1:0];
  assign stop_any  = stop_pend | stop;

  ir_decode u_ir_decode (
    .opcode     (opcode),
    .is_rtype   (is_rtype),
    .is_nop     (is_nop),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= cpu_ctrl_pkg::S_HALT;
      stop_pend <= 1'b0;
    end else begin
      state_q   <= state_d;
      stop_pend <= stop_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    PCout   = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    MARin   = 1'b0;
    MDRin   = 1'b0;
    PCin    = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    alu_op  = '0;
    illegal = 1'b0;
    case (state_q)
      cpu_ctrl_pkg::S_HALT: begin
        if (start && !stop) state_d = cpu_ctrl_pkg::S_T0;
      end
      cpu_ctrl_pkg::S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        state_d = cpu_ctrl_pkg::S_T1;
      end
      cpu_ctrl_pkg::S_T1: begin
        // PCin repeats harmlessly during wait cycles since Z holds PC+1.
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (mem_ready) state_d = cpu_ctrl_pkg::S_T2;
      end
      cpu_ctrl_pkg::S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = cpu_ctrl_pkg::S_T3;
      end
      cpu_ctrl_pkg::S_T3: begin
        if (is_rtype) begin
          Grb     = 1'b1;
          Rout    = 1'b1;
          Yin     = 1'b1;
          state_d = cpu_ctrl_pkg::S_T4;
        end else if (is_halt) begin
          state_d = cpu_ctrl_pkg::S_HALT;
        end else begin
          illegal = is_illegal & ~is_nop;
          state_d = stop_any ? cpu_ctrl_pkg::S_HALT : cpu_ctrl_pkg::S_T0;
        end
      end
      cpu_ctrl_pkg::S_T4: begin
        Grc     = 1'b1;
        Rout    = 1'b1;
        Zin     = 1'b1;
        alu_op  = OPW'(opcode);
        state_d = cpu_ctrl_pkg::S_T5;
      end
      cpu_ctrl_pkg::S_T5: begin
        Zlowout = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
        state_d = stop_any ? cpu_ctrl_pkg::S_HALT : cpu_ctrl_pkg::S_T0;
      end
      default: state_d = cpu_ctrl_pkg::S_HALT;
    endcase
    run         = (state_q != cpu_ctrl_pkg::S_HALT);
    stop_pend_d = (state_d == cpu_ctrl_pkg::S_HALT) ? 1'b0 : stop_any;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired sequencer for the single-bus `DataPath`. It drives every bus-source, register-enable, memory and ALU strobe for the fetch cycle (T0–T2) and for register-to-register ALU instructions (T3–T5). The bench-side state machine that hand-drove those strobes is replaced by this block. It takes the instruction register and a memory-ready handshake as inputs, and drives the `DataPath` control inputs plus the register-select lines (`Gra`/`Grb`/`Grc`, `Rin`/`Rout`) consumed by the select-and-encode logic.

## Interface
Parameters:
- `OPW`, 5: opcode width, `IR[31:27]`.

Ports:
- `clock` in 1: single system clock; all state changes on rising edge.
- `clear` in 1: asynchronous, active-high reset.
- `IR` in 32: instruction register contents from the datapath.
- `mem_ready` in 1: memory read data valid this cycle.
- `start` in 1: leave HALT and begin fetching.
- `stop` in 1: request halt at the next instruction boundary.
- `PCout`, `Zlowout`, `MDRout` out 1 each: bus source selects.
- `MARin`, `MDRin`, `PCin`, `IRin`, `Yin`, `Zin` out 1 each: register load enables.
- `IncPC`, `Read` out 1 each: PC increment via ALU; MDR mux selects memory.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout` out 1 each: general-register field select and direction.
- `alu_op` out `OPW`: ALU operation; equals the opcode in T4, else 0.
- `run` out 1: high in every state except HALT.
- `illegal` out 1: one-cycle pulse on an undefined opcode.

## Operation
- Opcodes:
  - `ADD`=5'b00011, `SUB`=5'b00100, `AND`=5'b00101, `OR`=5'b00110: R-type.
  - `NOP`=5'b11010, `HALT`=5'b11011.
  - All others are illegal.
- Fields: `Ra`=`IR[26:23]` (destination), `Rb`=`IR[22:19]`, `Rc`=`IR[18:15]`.
- States: HALT, T0, T1, T2, T3, T4, T5. Outputs are decoded from the present state, plus `IR` opcode in T3/T4. Every unlisted output is 0.
  - T0: `PCout`, `MARin`, `IncPC`, `Zin`. Next state T1.
  - T1: `Zlowout`, `PCin`, `Read`, `MDRin`. Stay in T1 while `mem_ready`=0; otherwise go to T2. Re-asserting `PCin` while waiting is harmless because Z is unchanged.
  - T2: `MDRout`, `IRin`. Next state T3.
  - T3, R-type: `Grb`, `Rout`, `Yin`. Next state T4.
  - T3, NOP: no strobes. Next state is T0, or HALT if stop is pending.
  - T3, HALT opcode: no strobes. Next state HALT.
  - T3, illegal: `illegal`=1. Next state is T0, or HALT if stop is pending.
  - T4: `Grc`, `Rout`, `Zin`, `alu_op`=opcode. Next state T5.
  - T5: `Zlowout`, `Gra`, `Rin`. Next state is T0, or HALT if stop is pending.
  - HALT: all strobes 0, `run`=0. Go to T0 when `start`=1 and `stop`=0.
- Stop handling:
  - `stop` sets an internal `stop_pend` flag on any edge where it is high.
  - The flag is consumed at an instruction boundary (exit of T5, or exit of T3 for NOP/illegal).
  - The flag is cleared on entry to HALT.
- `stop` and `start` high together in HALT: stay in HALT.

## Timing
- Reset values: state=HALT, `stop_pend`=0, all outputs 0, `run`=0. Reset takes effect immediately and asynchronously, including mid-instruction. No partial write completes after `clear` rises.
- Strobes are valid for the whole cycle of their state. Datapath registers load at the rising edge that ends the state.
- `IR` is sampled only in T3/T4; it is valid from the edge that ends T2.
- R-type latency: 6 cycles from T0 entry to `Ra` written, with `mem_ready` high in the first T1 cycle. Each wait cycle adds 1.
- NOP, HALT and illegal instructions take 4 cycles.
- Throughput: back-to-back instructions with no idle cycle between T5 and the next T0.
- `start` to first `PCout`: 1 cycle.

## Structure
- Package `cpu_ctrl_pkg`: opcode constants, state enum/encoding, IR field bit positions, `OPW`.
- One natural sub-module, `ir_decode`: combinational opcode classification producing `is_rtype`, `is_nop`, `is_halt`, `is_illegal`.
- Everything else lives in `control_unit`: state register, `stop_pend`, output decode.

## Test plan
- Reset then `start`: `IR`=32'h28918000 (`and R1,R2,R3`), `mem_ready` tied 1. Expect T0–T5 in 6 cycles, `alu_op`=5'b00101 in T4, and R1 = R2 & R3 (0x14 & 0x12 = 0x10).
- Same instruction with `mem_ready` low for 3 cycles. Expect T1 held for 4 cycles, `Read`/`MDRin` high throughout, total 9 cycles.
- `IR` opcode 5'b11111. Expect a one-cycle `illegal` pulse in T3, no `Yin`/`Rin`, and return to T0 after 4 cycles.
- `stop` pulsed during T4 of an ADD. Expect T5 to complete, then HALT with `run`=0. A later `start` resumes at T0.
- `clear` asserted in T4. Expect all outputs 0 and state HALT immediately, without waiting for a clock edge. `Rin` is never asserted.
- HALT opcode followed by `start` and `stop` both high. Expect the block to remain in HALT.
